// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU; single-cycle ops register in one cycle,
// MULU/DIVU/REMU iterate one bit per cycle (shift-add / restoring division).
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] portOut,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             div0
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [3:0] MULU = 4'd10, DIVU = 4'd11, REMU = 4'd12;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           r_state;
  logic [3:0]       r_op;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_acc, r_x, r_y;
  logic [WIDTH-1:0] w_sum, w_diff, w_res, w_mul_acc, w_rem, w_q, w_long_res, w_val;
  logic [WIDTH:0]   w_shift, w_trial;
  logic             w_long, w_dz, w_ovf, w_ge, w_start, w_go_busy, w_last, w_load;
  assign w_sum     = portA + portB;
  assign w_diff    = portA - portB;
  assign w_long    = aluop inside {MULU, DIVU, REMU};
  assign w_dz      = (aluop == DIVU || aluop == REMU) && portB == '0;
  assign w_ovf     = aluop == 4'd2 ? (portA[WIDTH-1] == portB[WIDTH-1] && w_sum[WIDTH-1] != portA[WIDTH-1]) :
                     aluop == 4'd3 ? (portA[WIDTH-1] != portB[WIDTH-1] && w_diff[WIDTH-1] != portA[WIDTH-1]) : 1'b0;
  always_comb begin
    w_res = '0;
    case (aluop)
      4'd0:  w_res = portA << portB[SHW-1:0];
      4'd1:  w_res = portA >> portB[SHW-1:0];
      4'd2:  w_res = w_sum;
      4'd3:  w_res = w_diff;
      4'd4:  w_res = portA & portB;
      4'd5:  w_res = portA | portB;
      4'd6:  w_res = portA ^ portB;
      4'd7:  w_res = ~(portA | portB);
      4'd8:  w_res = WIDTH'($signed(portA) < $signed(portB));
      4'd9:  w_res = WIDTH'(portA < portB);
      DIVU:  w_res = '1;
      REMU:  w_res = portA;
      default: w_res = '0;
    endcase
  end
  // r_acc is the product (MULU) or partial remainder (DIVU/REMU); r_x shifts the dividend out and quotient in
  assign w_mul_acc  = r_acc + (r_y[0] ? r_x : '0);
  assign w_shift    = {r_acc, r_x[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_y};
  assign w_ge       = ~w_trial[WIDTH];
  assign w_rem      = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_q        = {r_x[WIDTH-2:0], w_ge};
  assign w_long_res = r_op == MULU ? w_mul_acc : r_op == DIVU ? w_q : w_rem;
  assign w_start    = r_state == IDLE && in_valid;
  assign w_go_busy  = w_start && w_long && !w_dz;
  assign w_last     = r_state == BUSY && r_cnt == SHW'(WIDTH - 1);
  assign w_load     = (w_start && !w_go_busy) || w_last;
  assign w_val      = r_state == BUSY ? w_long_res : w_res;
  assign in_ready   = r_state == IDLE;
  assign out_valid  = r_state == DONE;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      portOut  <= '0;
      negative <= 1'b0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      div0     <= 1'b0;
    end else begin
      if (w_load) begin
        portOut  <= w_val;
        negative <= w_val[WIDTH-1];
        zero     <= w_val == '0;
        overflow <= r_state == IDLE && w_ovf;
        div0     <= r_state == IDLE && w_dz;
      end
      case (r_state)
        IDLE: if (in_valid) begin
          r_op    <= aluop;
          r_cnt   <= '0;
          r_acc   <= '0;
          r_x     <= portA;
          r_y     <= portB;
          r_state <= w_go_busy ? BUSY : DONE;
        end
        BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= r_op == MULU ? w_mul_acc : w_rem;
          r_x   <= r_op == MULU ? r_x << 1 : w_q;
          r_y   <= r_op == MULU ? r_y >> 1 : r_y;
          if (w_last) r_state <= DONE;
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table plus hand sequences for latency, backpressure and reset.
module tb_seq_alu;
  logic clk = 0, nRST = 0;
  logic iv, ir, ov, ordy, n, z, v, d;
  logic [3:0] op;
  logic [31:0] a, b, po;
  logic iv8, ir8, ov8, n8, z8, v8, d8;
  logic [3:0] op8;
  logic [7:0] a8, b8, po8;
  int checks = 0, errors = 0;
  typedef struct {logic [3:0] op; logic [31:0] a, b, res; logic [3:0] fl; int lat;} vec_t;
  vec_t vt[23];

  seq_alu #(.WIDTH(32)) u32 (.CLK(clk), .nRST(nRST), .in_valid(iv), .in_ready(ir), .aluop(op),
    .portA(a), .portB(b), .out_valid(ov), .out_ready(ordy), .portOut(po), .negative(n),
    .zero(z), .overflow(v), .div0(d));
  seq_alu #(.WIDTH(8)) u8 (.CLK(clk), .nRST(nRST), .in_valid(iv8), .in_ready(ir8), .aluop(op8),
    .portA(a8), .portB(b8), .out_valid(ov8), .out_ready(ordy), .portOut(po8), .negative(n8),
    .zero(z8), .overflow(v8), .div0(d8));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic run32(input vec_t t, input string nm);
    int k;
    bit busy_ok;
    @(negedge clk);
    iv = 1; op = t.op; a = t.a; b = t.b;
    chk({nm, "_ready"}, ir, 1);
    @(posedge clk); #1;
    iv = 0; op = 4'd2; a = ~t.a; b = 32'h1;
    k = 0; busy_ok = 1;
    while (!ov && k < 100) begin
      if (ir) busy_ok = 0;
      iv = k[0];
      @(posedge clk); #1;
      k++;
    end
    iv = 0;
    chk({nm, "_lat"}, k, t.lat);
    chk({nm, "_busy_noready"}, busy_ok, 1);
    chk({nm, "_res"}, {po, n, z, v, d}, {t.res, t.fl});
    chk({nm, "_done_noready"}, ir, 0);
    @(posedge clk); #1;
    chk({nm, "_idle"}, {ir, ov}, 2'b10);
  endtask

  task automatic run8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] res, input logic [3:0] fl, input int lat, input string nm);
    int k;
    @(negedge clk);
    iv8 = 1; op8 = o; a8 = x; b8 = y;
    @(posedge clk); #1;
    iv8 = 0; a8 = ~x; b8 = ~y;
    k = 0;
    while (!ov8 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_lat"}, k, lat);
    chk({nm, "_res"}, {po8, n8, z8, v8, d8}, {res, fl});
    @(posedge clk); #1;
    chk({nm, "_idle"}, {ir8, ov8}, 2'b10);
  endtask

  initial begin
    int k;
    bit quiet;
    vt = '{
      '{4'd2,  32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1010, 0},
      '{4'd3,  32'h5,        32'h5,        32'h0,        4'b0100, 0},
      '{4'd8,  32'hFFFFFFFF, 32'h1,        32'h1,        4'b0000, 0},
      '{4'd9,  32'hFFFFFFFF, 32'h1,        32'h0,        4'b0100, 0},
      '{4'd0,  32'h1,        32'h25,       32'h20,       4'b0000, 0},
      '{4'd1,  32'h80000000, 32'h3F,       32'h1,        4'b0000, 0},
      '{4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 0},
      '{4'd5,  32'h0F0F0000, 32'hF0,       32'h0F0F00F0, 4'b0000, 0},
      '{4'd6,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 4'b0000, 0},
      '{4'd7,  32'h0,        32'h0,        32'hFFFFFFFF, 4'b1000, 0},
      '{4'd3,  32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0010, 0},
      '{4'd2,  32'hFFFFFFFF, 32'h1,        32'h0,        4'b0100, 0},
      '{4'd10, 32'h00010003, 32'h7,        32'h00070015, 4'b0000, 32},
      '{4'd11, 32'd100,      32'd7,        32'd14,       4'b0000, 32},
      '{4'd12, 32'd100,      32'd7,        32'd2,        4'b0000, 32},
      '{4'd11, 32'h1234,     32'h0,        32'hFFFFFFFF, 4'b1001, 0},
      '{4'd12, 32'h1234,     32'h0,        32'h1234,     4'b0001, 0},
      '{4'd13, 32'h5,        32'h3,        32'h0,        4'b0100, 0},
      '{4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        4'b0000, 32},
      '{4'd12, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 4'b0000, 32},
      '{4'd11, 32'hFFFFFFFF, 32'h80000001, 32'h1,        4'b0000, 32},
      '{4'd8,  32'h1,        32'hFFFFFFFF, 32'h0,        4'b0100, 0},
      '{4'd10, 32'h5,        32'h0,        32'h0,        4'b0100, 32}
    };
    iv = 0; op = 0; a = 0; b = 0; ordy = 1;
    iv8 = 0; op8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(posedge clk); #1;
    chk("reset_state", {ir, ov, po, n, z, v, d}, {1'b1, 1'b0, 32'h0, 4'b0100});
    @(negedge clk); nRST = 1;
    foreach (vt[i]) run32(vt[i], $sformatf("v%0d", i));

    // Backpressure: result and flags must hold while out_ready is low
    ordy = 0;
    @(negedge clk);
    iv = 1; op = 4'd2; a = 32'h40000000; b = 32'h40000000;
    @(posedge clk); #1;
    iv = 0; a = 0; b = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i), {po, n, z, v, d, ir, ov}, {32'h80000000, 4'b1010, 1'b0, 1'b1});
      @(posedge clk); #1;
    end
    ordy = 1;
    @(posedge clk); #1;
    chk("bp_release", {ir, ov}, 2'b10);

    // Reset in the middle of a DIVU
    @(negedge clk);
    iv = 1; op = 4'd11; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    iv = 0;
    repeat (5) @(posedge clk);
    @(negedge clk); nRST = 0;
    #1 chk("midbusy_reset", {ir, ov, z, po}, {3'b101, 32'h0});
    @(negedge clk); nRST = 1;
    quiet = 1;
    for (k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ov) quiet = 0;
    end
    chk("no_spurious_result", quiet, 1);

    run8(4'd10, 8'h0F, 8'h11, 8'hFF, 4'b1000, 8, "w8_mulu");
    run8(4'd11, 8'hFF, 8'h10, 8'h0F, 4'b0000, 8, "w8_divu");
    run8(4'd0,  8'h01, 8'h0B, 8'h08, 4'b0000, 0, "w8_sll");
    run8(4'd2,  8'h7F, 8'h01, 8'h80, 4'b1010, 0, "w8_add_ovf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
